// File: rtl/burst_frame_extractor_pkg.sv
// Shared types and helpers for upstream burst delineation.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package burst_frame_extractor_pkg;

    // Burst delineation states: search for a syncword, wait out the
    // detect-to-data gap, parse the header, stream payload, then hold off.
    typedef enum logic [2:0] {
        ST_SEARCH  = 3'd0,
        ST_ALIGN   = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_GUARD   = 3'd4
    } state_e;

    // Header word layout: {length[15:0], onu_id[7:0], check[7:0]}
    localparam int HDR_LEN_MSB = 31;
    localparam int HDR_LEN_LSB = 16;
    localparam int HDR_ONU_MSB = 15;
    localparam int HDR_ONU_LSB = 8;
    localparam int HDR_CHK_MSB = 7;
    localparam int HDR_CHK_LSB = 0;

    // Check byte is the XOR of the three upper header bytes.
    function automatic logic [7:0] hdr_check(input logic [31:0] hdr);
        return hdr[31:24] ^ hdr[23:16] ^ hdr[15:8];
    endfunction

    // Saturating 16-bit increment used by the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/burst_frame_extractor_header_checker.sv
// Splits a burst header word into fields and judges whether it is acceptable.
// Latency: combinational.
// Backpressure: n/a.
module burst_header_checker
    import burst_frame_extractor_pkg::*;
#(
    parameter int MAX_BURST_WORDS = 4096
) (
    input  logic [31:0] hdr_i,
    output logic [15:0] length_o,
    output logic [7:0]  onu_id_o,
    output logic        hdr_ok_o
);

    localparam logic [31:0] MAX_LEN = 32'(MAX_BURST_WORDS);

    logic       chk_ok;
    logic       len_ok;

    assign length_o = hdr_i[HDR_LEN_MSB:HDR_LEN_LSB];
    assign onu_id_o = hdr_i[HDR_ONU_MSB:HDR_ONU_LSB];

    // Header is accepted only with a matching check byte and a legal, non-zero length
    always_comb begin
        chk_ok   = (hdr_i[HDR_CHK_MSB:HDR_CHK_LSB] == hdr_check(hdr_i));
        len_ok   = (length_o != 16'd0) && ({16'd0, length_o} <= MAX_LEN);
        hdr_ok_o = chk_ok && len_ok;
    end

endmodule

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously, releases on the second clock edge.
// Latency: assertion immediate, deassertion 2 clock cycles.
// Backpressure: n/a.
module reset_sync (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_o
);

    logic [1:0] sync_q;

    // Two-stage shift so the released reset edge is clean in the clk_i domain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rst_o = sync_q[1];

endmodule

// File: rtl/burst_frame_extractor.sv
// Delineates one upstream burst: syncword detect, header parse, framed payload out.
// Latency: payload word appears on out_data one cycle after it is on in_data.
// Backpressure: none; payload streams one word per cycle, no ready input.
module burst_frame_extractor
    import burst_frame_extractor_pkg::*;
#(
    parameter int DETECT_TO_DATA_DELAY = 8,
    parameter int MAX_BURST_WORDS      = 4096,
    parameter int GUARD_WORDS          = 4
) (
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic [31:0] in_data,
    input  logic        in_detected,
    output logic        out_sync_enable,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic [7:0]  out_onu_id,
    output logic        out_hdr_error,
    output logic [15:0] out_burst_count,
    output logic [15:0] out_error_count
);

    localparam logic [3:0] DLY_LOAD   = 4'(DETECT_TO_DATA_DELAY - 1);
    localparam logic [3:0] GUARD_LOAD = (GUARD_WORDS > 0) ? 4'(GUARD_WORDS - 1) : 4'd0;
    // With no guard interval the search window re-opens right after the burst.
    localparam state_e     POST_ST    = (GUARD_WORDS == 0) ? ST_SEARCH : ST_GUARD;

    logic        rst_sync;

    state_e      state_q, state_d;
    logic [3:0]  dly_q, dly_d;
    logic [3:0]  guard_q, guard_d;
    logic [15:0] remaining_q, remaining_d;
    logic        first_q, first_d;
    logic [7:0]  onu_q, onu_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        hdr_err_q, hdr_err_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [15:0] hdr_len;
    logic [7:0]  hdr_onu;
    logic        hdr_ok;

    reset_sync u_reset_sync (
        .clk_i (in_clock),
        .rst_i (in_reset),
        .rst_o (rst_sync)
    );

    burst_header_checker #(
        .MAX_BURST_WORDS (MAX_BURST_WORDS)
    ) u_header_checker (
        .hdr_i    (in_data),
        .length_o (hdr_len),
        .onu_id_o (hdr_onu),
        .hdr_ok_o (hdr_ok)
    );

    // Next-state logic: burst delineation FSM plus framing and counter updates
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        guard_d     = guard_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        onu_d       = onu_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        hdr_err_d   = 1'b0;
        burst_cnt_d = burst_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_SEARCH: begin
                if (in_detected) begin
                    state_d = ST_ALIGN;
                    dly_d   = DLY_LOAD;
                end
            end
            ST_ALIGN: begin
                // Extra detects are ignored; the bit shift is already frozen.
                if (dly_q == 4'd0) begin
                    state_d = ST_HEADER;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end
            ST_HEADER: begin
                if (!hdr_ok) begin
                    hdr_err_d = 1'b1;
                    err_cnt_d = sat_inc16(err_cnt_q);
                    guard_d   = GUARD_LOAD;
                    state_d   = POST_ST;
                end else begin
                    onu_d       = hdr_onu;
                    remaining_d = hdr_len - 16'd1;
                    first_d     = 1'b1;
                    state_d     = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                data_d  = in_data;
                valid_d = 1'b1;
                sop_d   = first_q;
                first_d = 1'b0;
                if (remaining_q == 16'd0) begin
                    eop_d       = 1'b1;
                    burst_cnt_d = sat_inc16(burst_cnt_q);
                    guard_d     = GUARD_LOAD;
                    state_d     = POST_ST;
                end else begin
                    remaining_d = remaining_q - 16'd1;
                end
            end
            ST_GUARD: begin
                // A detect arriving on the last guard cycle is deliberately dropped.
                if (guard_q == 4'd0) begin
                    state_d = ST_SEARCH;
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // State, counters and registered outputs; reset abandons any partial burst
    always_ff @(posedge in_clock or posedge rst_sync) begin
        if (rst_sync) begin
            state_q     <= ST_SEARCH;
            dly_q       <= 4'd0;
            guard_q     <= 4'd0;
            remaining_q <= 16'd0;
            first_q     <= 1'b0;
            onu_q       <= 8'd0;
            data_q      <= 32'd0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            hdr_err_q   <= 1'b0;
            burst_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            guard_q     <= guard_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            onu_q       <= onu_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            hdr_err_q   <= hdr_err_d;
            burst_cnt_q <= burst_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_sync_enable = (state_q == ST_SEARCH);
    assign out_data        = data_q;
    assign out_valid       = valid_q;
    assign out_sop         = sop_q;
    assign out_eop         = eop_q;
    assign out_onu_id      = onu_q;
    assign out_hdr_error   = hdr_err_q;
    assign out_burst_count = burst_cnt_q;
    assign out_error_count = err_cnt_q;

endmodule
